// File: rtl/shiftreg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shiftreg_ctrl_pkg
//   Shared types and helpers for the shift-register serializer controller.
//   - state_t : sequencer states (INIT, IDLE, LOAD, SHIFT, GAP)
//   - CNT_W   : counter width needed to count 0..n-1 (never less than 1 bit)
// -----------------------------------------------------------------------------
package shiftreg_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    function automatic int CNT_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : shiftreg_ctrl_pkg

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
//   Mod-N up-counter with synchronous clear and count enable. tc_o is high
//   while the count sits at N-1, so the cycle that sees tc_o is the N-th
//   enabled cycle after a clear.
// Ports:
//   clock  in  rising-edge clock
//   rst    in  synchronous active-high reset (count <= 0)
//   clr_i  in  synchronous clear, dominates en_i
//   en_i   in  advance the count (wraps N-1 -> 0)
//   tc_o   out terminal count (count == N-1)
// -----------------------------------------------------------------------------
module bit_counter
    import shiftreg_ctrl_pkg::*;
#(
    parameter int N = 8,
    localparam int W = CNT_W(N)
) (
    input  logic clock,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : bit_counter

// File: rtl/shiftreg_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// shiftreg_serializer_ctrl
//   Sequencer that turns a parameterized shift register (LEFT direction) into
//   a parallel-in / serial-out transmitter. A word accepted on in_valid/in_ready
//   is loaded into the register, then shifted out MSB-first, one bit per cycle.
//   bit_valid marks cycles where the register's shiftout carries a frame bit;
//   frame_done pulses on the last bit; frames_sent counts completed frames.
// Ports:
//   clock, rst              clock and synchronous active-high reset
//   in_valid/in_ready       word handshake (ready only in IDLE)
//   in_data                 word to send, captured at the handshake
//   abort                   kills the frame in LOAD/SHIFT/GAP
//   sr_load/sr_enable/sr_sclr/sr_shiftin/sr_data   shift-register controls
//   bit_valid, frame_done   serial bit qualifier, end-of-frame pulse
//   busy                    high whenever not IDLE
//   frames_sent             completed-frame count, wraps to 0
// -----------------------------------------------------------------------------
module shiftreg_serializer_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int   SHIFT_WIDTH = 8,
    parameter int   GAP_CYCLES  = 1,
    parameter logic FILL_BIT    = 1'b0,
    parameter int   FCNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SHIFT_WIDTH-1:0] in_data,
    input  logic                   abort,
    output logic                   sr_load,
    output logic                   sr_enable,
    output logic                   sr_sclr,
    output logic                   sr_shiftin,
    output logic [SHIFT_WIDTH-1:0] sr_data,
    output logic                   bit_valid,
    output logic                   frame_done,
    output logic                   busy,
    output logic [FCNT_WIDTH-1:0]  frames_sent
);

    // A zero-length gap never reaches GAP; the counter just needs a legal N.
    localparam int GAP_N = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

    state_t                 state_q, state_d;
    logic [SHIFT_WIDTH-1:0] hold_q,  hold_d;
    logic [FCNT_WIDTH-1:0]  fcnt_q,  fcnt_d;
    logic                   last_bit;
    logic                   gap_tc;
    logic                   in_shift;
    logic                   in_gap;

    assign in_shift = (state_q == SHIFT);
    assign in_gap   = (state_q == GAP);

    // Both counters restart from 0 on every entry into their state.
    bit_counter #(.N(SHIFT_WIDTH)) u_bit_cnt (
        .clock (clock),
        .rst   (rst),
        .clr_i (!in_shift),
        .en_i  (in_shift),
        .tc_o  (last_bit)
    );

    bit_counter #(.N(GAP_N)) u_gap_cnt (
        .clock (clock),
        .rst   (rst),
        .clr_i (!in_gap),
        .en_i  (in_gap),
        .tc_o  (gap_tc)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        hold_d     = hold_q;
        fcnt_d     = fcnt_q;
        in_ready   = 1'b0;
        sr_load    = 1'b0;
        sr_enable  = 1'b0;
        sr_sclr    = 1'b0;
        sr_shiftin = 1'b0;
        sr_data    = '0;
        bit_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;

        unique case (state_q)
            INIT: begin
                sr_sclr   = 1'b1;
                sr_enable = 1'b1;
                state_d   = IDLE;
            end
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_load   = 1'b1;
                sr_enable = 1'b1;
                sr_data   = hold_q;
                state_d   = abort ? INIT : SHIFT;
            end
            SHIFT: begin
                sr_enable  = 1'b1;
                sr_shiftin = FILL_BIT;
                bit_valid  = 1'b1;
                if (abort) begin
                    // An abort on the last bit still discards the frame.
                    state_d = INIT;
                end else if (last_bit) begin
                    frame_done = 1'b1;
                    fcnt_d     = fcnt_q + FCNT_WIDTH'(1);
                    state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = INIT;
                end else if (gap_tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign frames_sent = fcnt_q;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= INIT;
            // NOTE: the hold register is a plain datapath register, cheap to
            // reset, so it is cleared to keep sr_data free of X after reset.
            hold_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule : shiftreg_serializer_ctrl

// File: tb/tb_shiftreg_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shiftreg_serializer_ctrl
//   Drives the controller together with a behavioural LEFT shift register.
//   Accepted words are expanded MSB-first into an expected-bit queue; a
//   negedge monitor pops one entry per bit_valid cycle and also tracks the
//   expected completed-frame count.
// -----------------------------------------------------------------------------
module tb_shiftreg_serializer_ctrl;

    localparam int W    = 8;
    localparam int GAPC = 2;
    localparam int FCW  = 2;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic           clock = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           abort = 1'b0;
    logic           sr_load, sr_enable, sr_sclr, sr_shiftin;
    logic [W-1:0]   sr_data;
    logic           bit_valid, frame_done, busy;
    logic [FCW-1:0] frames_sent;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   exp_frames = 0;
    int   last_fd_cyc = -100;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    shiftreg_serializer_ctrl #(
        .SHIFT_WIDTH (W),
        .GAP_CYCLES  (GAPC),
        .FILL_BIT    (1'b0),
        .FCNT_WIDTH  (FCW)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .abort       (abort),
        .sr_load     (sr_load),
        .sr_enable   (sr_enable),
        .sr_sclr     (sr_sclr),
        .sr_shiftin  (sr_shiftin),
        .sr_data     (sr_data),
        .bit_valid   (bit_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural shift register: enable gates everything, sclr beats load.
    logic [W-1:0] sr_q;
    logic         shiftout;
    assign shiftout = sr_q[W-1];
    always_ff @(posedge clock) begin
        if (sr_enable) begin
            if (sr_sclr)      sr_q <= '0;
            else if (sr_load) sr_q <= sr_data;
            else              sr_q <= {sr_q[W-2:0], sr_shiftin};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: scoreboard pop on every serial bit, frame count every cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            check("frames_sent", {30'd0, frames_sent}, exp_frames % (1 << FCW));
            if (bit_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_bit", {31'd0, bit_valid}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("shiftout", {31'd0, shiftout}, {31'd0, mon_e.b});
                    check("frame_done", {31'd0, frame_done}, {31'd0, mon_e.last && !abort});
                    check("shiftin_fill", {31'd0, sr_shiftin}, 0);
                    if (mon_e.last && !abort) begin
                        exp_frames++;
                        last_fd_cyc = cyc;
                    end
                end
            end else begin
                check("frame_done_idle", {31'd0, frame_done}, 0);
            end
            if (rst) exp_frames = 0;
        end
    end

    task automatic send(input logic [W-1:0] w, input bit keep, output int acc_cyc);
        bit hs;
        hs       = 1'b0;
        acc_cyc  = -1;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 60 && !hs; i++) begin
            hs      = in_ready;
            acc_cyc = cyc;
            tick();
        end
        if (!hs) begin
            check("accept_timeout", {31'd0, hs}, 1);
        end else begin
            for (int i = W - 1; i >= 0; i--) sb.push_back('{w[i], (i == 0)});
        end
        if (!keep) in_valid = 1'b0;
        in_data = W'($urandom);   // later changes must not reach the frame
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        check("reach_idle", {31'd0, in_ready}, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    // j counts cycles from LOAD: 0 = LOAD, 1..W = SHIFT bit j-1, then GAP.
    task automatic abort_after(input int j);
        repeat (j) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
    endtask

    initial begin
        int a1, a2;
        logic [W-1:0] w;

        // 1. reset -> INIT then IDLE
        repeat (2) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        check("init_sclr",     {31'd0, sr_sclr}, 1);
        check("init_enable",   {31'd0, sr_enable}, 1);
        check("init_in_ready", {31'd0, in_ready}, 0);
        check("init_busy",     {31'd0, busy}, 1);
        check("init_frames",   {30'd0, frames_sent}, 0);
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 1);
        check("idle_busy",     {31'd0, busy}, 0);
        check("idle_enable",   {31'd0, sr_enable}, 0);

        // 2. single word A5
        send(8'hA5, 1'b0, a1);
        check("load_sr_load", {31'd0, sr_load}, 1);
        check("load_sr_data", {24'd0, sr_data}, 32'hA5);
        check("load_enable",  {31'd0, sr_enable}, 1);
        check("load_no_bit",  {31'd0, bit_valid}, 0);
        wait_idle();
        check("frames_after_one", {30'd0, frames_sent}, 1);

        // 3. back-to-back with in_valid held, gap of 2
        send(8'hA5, 1'b1, a1);
        send(8'h3C, 1'b0, a2);
        check("ready_return_gap", a2 - last_fd_cyc, GAPC + 1);
        wait_idle();
        check("frames_after_three", {30'd0, frames_sent}, 3);

        // 4. abort on the 4th SHIFT cycle
        send(8'hF0, 1'b0, a1);
        abort_after(4);
        check("abort_init_sclr", {31'd0, sr_sclr}, 1);
        check("abort_no_done",   {31'd0, frame_done}, 0);
        tick();
        check("abort_reg_clear", {24'd0, sr_q}, 0);
        wait_idle();
        check("abort_frames",    {30'd0, frames_sent}, 3);

        // 5. abort coincident with the last bit
        send(8'h81, 1'b0, a1);
        abort_after(W);
        check("abort_last_sclr", {31'd0, sr_sclr}, 1);
        wait_idle();
        check("abort_last_frames", {30'd0, frames_sent}, 3);

        // 6. reset in LOAD, reset mid-SHIFT, then counter wrap
        send(8'h55, 1'b0, a1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("rst_load_sclr",   {31'd0, sr_sclr}, 1);
        check("rst_load_frames", {30'd0, frames_sent}, 0);
        wait_idle();
        send(8'hC3, 1'b0, a1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("rst_shift_sclr",   {31'd0, sr_sclr}, 1);
        check("rst_shift_frames", {30'd0, frames_sent}, 0);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            send(W'($urandom), 1'b0, a1);
            wait_idle();
        end
        check("frames_three", {30'd0, frames_sent}, 3);
        send(W'($urandom), 1'b0, a1);
        wait_idle();
        check("frames_wrap", {30'd0, frames_sent}, 0);

        // Random traffic with occasional aborts
        for (int it = 0; it < 30; it++) begin
            w = W'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            send(w, 1'b0, a1);
            if ($urandom_range(0, 3) == 0) abort_after($urandom_range(0, W + GAPC));
            wait_idle();
        end

        repeat (4) tick();
        check("final_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule : tb_shiftreg_serializer_ctrl
